// File: rtl/sipo_rx_if.sv
// Bus bundle for sipo_rx: serial input side plus the parallel valid/ready output side.
interface sipo_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             shift_en;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             parity_err;

  // master drives the serial stream and consumes words; slave is the receiver
  modport master (
    output shift_en, serial_in, out_ready,
    input  parallel_out, out_valid, overrun, parity_err
  );

  modport slave (
    input  shift_en, serial_in, out_ready,
    output parallel_out, out_valid, overrun, parity_err
  );
endinterface

// File: rtl/sipo_rx.sv
// MSB-first serial-to-parallel receiver with a valid/ready holding register and sticky overrun.
// Optional even-parity frame bit enabled by defining SIPO_RX_PARITY_EN.
module sipo_rx #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  input logic      clear,
  sipo_rx_if.slave bus
);

`ifdef SIPO_RX_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned    CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;

  assign shifted = {sreg_q[WIDTH-2:0], bus.serial_in};

`ifdef SIPO_RX_PARITY_EN
  logic perr_q, perr_d;
  // parity bit is the last frame bit; the data word is already complete in sreg
  assign word           = sreg_q;
  assign bus.parity_err = perr_q;
`else
  assign word           = shifted;
  assign bus.parity_err = 1'b0;
`endif

  // next-state: clear first, then shift/complete, then holding-register handshake
  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    done    = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (clear) begin
      sreg_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
`ifdef SIPO_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      if (bus.shift_en) begin
        done  = (cnt_q == LAST);
        cnt_d = done ? '0 : cnt_q + CNT_W'(1);
`ifdef SIPO_RX_PARITY_EN
        if (!done) sreg_d = shifted;
`else
        sreg_d = shifted;
`endif
      end
      if (done) begin
        // load when free or being drained this edge; otherwise drop and flag
        if (!valid_q || bus.out_ready) begin
          hold_d  = word;
          valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
          perr_d  = ^{sreg_q, bus.serial_in};
`endif
        end else begin
          ovr_d = 1'b1;
        end
      end else if (valid_q && bus.out_ready) begin
        valid_d = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.parallel_out = hold_q;
  assign bus.out_valid    = valid_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed scenarios plus random traffic against a bit-queue model.
module tb_sipo_rx;
  localparam int unsigned W = 8;
`ifdef SIPO_RX_PARITY_EN
  localparam int unsigned FRAME = W + 1;
`else
  localparam int unsigned FRAME = W;
`endif

  logic clk;
  logic rst_n;
  logic clear;

  sipo_rx_if #(.WIDTH(W)) bus ();

  sipo_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: received bits of the current frame plus the delivered-word state
  bit           m_bits[$];
  logic [W-1:0] m_word;
  logic         m_valid;
  logic         m_ovr;
  logic         m_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_word  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_edge(input logic c, input logic se, input logic si, input logic rdy);
    logic [W-1:0] w;
    int           ones;
    bit           complete;
    complete = 1'b0;
    w        = '0;
    ones     = 0;
    if (!rst_n) begin
      model_reset();
    end else if (c) begin
      m_bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
    end else begin
      if (se) begin
        m_bits.push_back(si);
        if (m_bits.size() == FRAME) begin
          complete = 1'b1;
          for (int i = 0; i < int'(W); i++) w = {w[W-2:0], m_bits[i]};
          for (int i = 0; i < int'(FRAME); i++) ones += int'(m_bits[i]);
          m_bits.delete();
        end
      end
      if (complete) begin
        if (!m_valid || rdy) begin
          m_word  = w;
          m_valid = 1'b1;
`ifdef SIPO_RX_PARITY_EN
          m_perr  = (ones % 2) != 0;
`else
          m_perr  = 1'b0;
`endif
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
        m_perr  = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".valid"},  32'(bus.out_valid),    32'(m_valid));
    check({where, ".data"},   32'(bus.parallel_out), 32'(m_word));
    check({where, ".ovr"},    32'(bus.overrun),      32'(m_ovr));
    check({where, ".perr"},   32'(bus.parity_err),   32'(m_perr));
  endtask

  // drive inputs 1ns after an edge, advance one edge, update model, compare
  task automatic cycle(input logic c, input logic se, input logic si, input logic rdy);
    clear         = c;
    bus.shift_en  = se;
    bus.serial_in = si;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(c, se, si, rdy);
    #1;
    check_outputs("cyc");
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input logic rdy,
                           input logic rdy_last, input logic par_flip);
    logic last;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      last = (i == 0) && (FRAME == W);
      cycle(1'b0, 1'b1, w[i], last ? rdy_last : rdy);
      if (i != 0)
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, rdy);
    end
`ifdef SIPO_RX_PARITY_EN
    cycle(1'b0, 1'b1, (^w) ^ par_flip, rdy_last);
`else
    if (par_flip) $display("note: parity flip ignored without parity frame bit");
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.shift_en  = 1'b0;
    bus.serial_in = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #1;
    check("reset.valid", 32'(bus.out_valid), 32'd0);
    check("reset.data",  32'(bus.parallel_out), 32'd0);
    check("reset.ovr",   32'(bus.overrun), 32'd0);
    check("reset.perr",  32'(bus.parity_err), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // basic word
    send_word(8'hD5, 0, 1'b1, 1'b1, 1'b0);
    check("basic.valid", 32'(bus.out_valid), 32'd1);
    check("basic.data",  32'(bus.parallel_out), 32'hD5);
    check("basic.ovr",   32'(bus.overrun), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic.drop",  32'(bus.out_valid), 32'd0);

    // gapped input
    send_word(8'h3C, 3, 1'b1, 1'b1, 1'b0);
    check("gap.valid", 32'(bus.out_valid), 32'd1);
    check("gap.data",  32'(bus.parallel_out), 32'h3C);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // overrun
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 0, 1'b0, 1'b0, 1'b0);
    check("ovr.data",  32'(bus.parallel_out), 32'hA5);
    check("ovr.valid", 32'(bus.out_valid), 32'd1);
    check("ovr.flag",  32'(bus.overrun), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr.consumed", 32'(bus.out_valid), 32'd0);
    check("ovr.sticky",   32'(bus.overrun), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr.cleared",  32'(bus.overrun), 32'd0);
    check("clear.hold",   32'(bus.parallel_out), 32'hA5);

    // back-to-back with same-edge consume
    send_word(8'h01, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'h80, 0, 1'b0, 1'b1, 1'b0);
    check("b2b.valid", 32'(bus.out_valid), 32'd1);
    check("b2b.data",  32'(bus.parallel_out), 32'h80);
    check("b2b.ovr",   32'(bus.overrun), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // clear mid-word, with a same-edge handshake and shift that must be ignored
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(8'h81, 0, 1'b0, 1'b0, 1'b0);
    check("clrmid.data", 32'(bus.parallel_out), 32'h81);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-word
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rstmid.valid", 32'(bus.out_valid), 32'd0);
    check("rstmid.data",  32'(bus.parallel_out), 32'd0);
    check("rstmid.ovr",   32'(bus.overrun), 32'd0);
    check("rstmid.perr",  32'(bus.parity_err), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    send_word(8'h81, 0, 1'b0, 1'b0, 1'b0);
    check("rstmid.word", 32'(bus.parallel_out), 32'h81);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_RX_PARITY_EN
    send_word(8'hD5, 0, 1'b1, 1'b1, 1'b0);
    check("par.good.err",  32'(bus.parity_err), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hD5, 0, 1'b1, 1'b1, 1'b1);
    check("par.bad.data",  32'(bus.parallel_out), 32'hD5);
    check("par.bad.err",   32'(bus.parity_err), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("par.bad.clr",   32'(bus.parity_err), 32'd0);
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      cycle(logic'($urandom_range(0, 59) == 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
